// File: rtl/sd_spi_rx_timing_if.sv
// Start/busy handshake and receive-data bus between the SD SPI reader FSM
// and its timing/deserializer block.
interface sd_spi_rx_timing_if #(
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned WORD_SIZE    = 8
);
  logic                    wait_start;
  logic [COUNTER_SIZE-1:0] wait_count_to;
  logic                    wait_busy;
  logic                    des_start;
  logic                    des_data_in;
  logic [WORD_SIZE-1:0]    des_data_out;
  logic                    des_busy;
  logic                    des_rco;

  modport master (
    output wait_start, wait_count_to, des_start, des_data_in,
    input  wait_busy, des_data_out, des_busy, des_rco
  );

  modport slave (
    input  wait_start, wait_count_to, des_start, des_data_in,
    output wait_busy, des_data_out, des_busy, des_rco
  );
endinterface

// File: rtl/sd_spi_rx_timing.sv
// SCLK divider, SCLK-edge wait counter and MISO deserializer for the SD SPI
// reader, all on the fast clock so start pulses raise busy one clock later.
module sd_spi_rx_timing #(
  parameter int unsigned IN_FREQ      = 250,
  parameter int unsigned OUT_FREQ     = 2,
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned DATA_LENGTH  = 4096,
  parameter int unsigned WORD_SIZE    = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              sclk,
  sd_spi_rx_timing_if.slave bus
);
  localparam int unsigned HALF_RAW = IN_FREQ / (2 * OUT_FREQ);
  localparam int unsigned HALF     = (HALF_RAW > 0) ? HALF_RAW : 1;
  localparam int unsigned DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned WAIT_W   = COUNTER_SIZE + 1;
  localparam int unsigned TOT_W    = $clog2(DATA_LENGTH + 1);
  localparam int unsigned WORD_W   = $clog2(WORD_SIZE + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} run_state_e;

  logic [DIV_W-1:0]        div_cnt;
  logic                    rise_tick_c;

  run_state_e              wait_state, wait_state_nxt;
  logic [COUNTER_SIZE-1:0] wait_limit;
  logic [COUNTER_SIZE-1:0] wait_cnt;
  logic                    wait_hit_c;

  run_state_e              des_state, des_state_nxt;
  logic [WORD_SIZE-1:0]    des_shift;
  logic [WORD_SIZE-1:0]    des_shift_nxt_c;
  logic [WORD_W-1:0]       des_word;
  logic [WORD_W-1:0]       des_word_nxt_c;
  logic [TOT_W-1:0]        des_total;
  logic [TOT_W-1:0]        des_total_nxt_c;
  logic                    des_last_c;
  logic                    des_emit_c;
  logic [WORD_SIZE-1:0]    des_data_q;
  logic                    des_rco_q;

  // Free-running divider; sclk toggles every HALF clocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (div_cnt == DIV_W'(HALF - 1)) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign rise_tick_c = ~sclk & (div_cnt == DIV_W'(HALF - 1));

  // Next-state and datapath helpers for both engines.
  always_comb begin
    wait_state_nxt  = wait_state;
    des_state_nxt   = des_state;
    // Widened compare so a zero target completes on the first tick.
    wait_hit_c      = ({1'b0, wait_cnt} + WAIT_W'(1)) >= {1'b0, wait_limit};
    des_shift_nxt_c = {des_shift[WORD_SIZE-2:0], bus.des_data_in};
    des_word_nxt_c  = des_word + WORD_W'(1);
    des_total_nxt_c = des_total + TOT_W'(1);
    des_last_c      = (des_total_nxt_c == TOT_W'(DATA_LENGTH));
    des_emit_c      = (des_word_nxt_c == WORD_W'(WORD_SIZE)) || des_last_c;

    case (wait_state)
      ST_IDLE: if (bus.wait_start) wait_state_nxt = ST_BUSY;
      ST_BUSY: if (rise_tick_c && wait_hit_c) wait_state_nxt = ST_IDLE;
      default: wait_state_nxt = ST_IDLE;
    endcase

    case (des_state)
      ST_IDLE: if (bus.des_start) des_state_nxt = ST_BUSY;
      ST_BUSY: if (rise_tick_c && des_last_c) des_state_nxt = ST_IDLE;
      default: des_state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: ticks arriving in the start cycle are not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_state <= ST_IDLE;
      wait_limit <= '0;
      wait_cnt   <= '0;
    end else begin
      wait_state <= wait_state_nxt;
      if (wait_state == ST_IDLE && bus.wait_start) begin
        wait_limit <= bus.wait_count_to;
        wait_cnt   <= '0;
      end else if (wait_state == ST_BUSY && rise_tick_c) begin
        wait_cnt <= wait_cnt + COUNTER_SIZE'(1);
      end
    end
  end

  // Deserializer: MSB-first shift on each SCLK rise, emit on word or run end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      des_state  <= ST_IDLE;
      des_shift  <= '0;
      des_word   <= '0;
      des_total  <= '0;
      des_data_q <= '0;
      des_rco_q  <= 1'b0;
    end else begin
      des_state <= des_state_nxt;
      des_rco_q <= 1'b0;
      if (des_state == ST_IDLE && bus.des_start) begin
        des_shift <= '0;
        des_word  <= '0;
        des_total <= '0;
      end else if (des_state == ST_BUSY && rise_tick_c) begin
        des_total <= des_total_nxt_c;
        if (des_emit_c) begin
          des_data_q <= des_shift_nxt_c;
          des_rco_q  <= 1'b1;
          des_word   <= '0;
          des_shift  <= '0;
        end else begin
          des_shift <= des_shift_nxt_c;
          des_word  <= des_word_nxt_c;
        end
      end
    end
  end

  assign bus.wait_busy    = (wait_state == ST_BUSY);
  assign bus.des_busy     = (des_state == ST_BUSY);
  assign bus.des_data_out = des_data_q;
  assign bus.des_rco      = des_rco_q;
endmodule

// File: tb/tb_sd_spi_rx_timing.sv
// Directed bench for sd_spi_rx_timing: divider, wait counter, and two
// deserializer instances (16-bit and 7-bit runs) with SCLK = clock/8.
module tb_sd_spi_rx_timing;
  logic clock = 1'b0;
  logic reset;
  logic sclk16;
  logic sclk7;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_last [2];

  always #5 clock = ~clock;

  sd_spi_rx_timing_if #(.COUNTER_SIZE(8), .WORD_SIZE(8)) b16 ();
  sd_spi_rx_timing_if #(.COUNTER_SIZE(8), .WORD_SIZE(8)) b7 ();

  sd_spi_rx_timing #(
    .IN_FREQ(8), .OUT_FREQ(1), .COUNTER_SIZE(8), .DATA_LENGTH(16), .WORD_SIZE(8)
  ) dut16 (.clock(clock), .reset(reset), .sclk(sclk16), .bus(b16));

  sd_spi_rx_timing #(
    .IN_FREQ(8), .OUT_FREQ(1), .COUNTER_SIZE(8), .DATA_LENGTH(7), .WORD_SIZE(8)
  ) dut7 (.clock(clock), .reset(reset), .sclk(sclk7), .bus(b7));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_des(input bit sel, input logic start, input logic din);
    if (sel) begin
      b7.des_start   = start;
      b7.des_data_in = din;
    end else begin
      b16.des_start   = start;
      b16.des_data_in = din;
    end
  endtask

  function automatic logic [9:0] des_obs(input bit sel);
    if (sel) return {b7.des_busy, b7.des_rco, b7.des_data_out};
    return {b16.des_busy, b16.des_rco, b16.des_data_out};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, " sclk"}, 32'(sclk16), 32'd0);
    check_eq({tag, " wait_busy16"}, 32'(b16.wait_busy), 32'd0);
    check_eq({tag, " des16"}, 32'(des_obs(1'b0)), 32'd0);
    check_eq({tag, " des7"}, 32'(des_obs(1'b1)), 32'd0);
  endtask

  // Rising SCLK edges fall on clock edges where cyc % 8 == 4 after reset release.
  task automatic run_wait(input logic [7:0] count_to, input bit retrigger, input string tag);
    int c;
    int e;
    int n;
    int need;
    c    = cyc;
    e    = c + 1;
    n    = 0;
    need = (count_to == 8'd0) ? 1 : int'(count_to);
    while (n < need) begin
      e++;
      if (e % 8 == 4) n++;
    end
    b16.wait_start    = 1'b1;
    b16.wait_count_to = count_to;
    step();
    b16.wait_start = 1'b0;
    check_eq({tag, " busy@start"}, 32'(b16.wait_busy), 32'd1);
    while (cyc < e + 3) begin
      if (retrigger && cyc == c + 1) begin
        b16.wait_start    = 1'b1;
        b16.wait_count_to = 8'd1;
      end
      step();
      b16.wait_start = 1'b0;
      check_eq({tag, " busy"}, 32'(b16.wait_busy), 32'(cyc < e));
    end
  endtask

  task automatic run_capture(input bit sel, input bit align, input logic [15:0] stream,
                             input int len, input logic [7:0] w0, input logic [7:0] w1,
                             input int stop_at, input string tag);
    int         k;
    int         r;
    bit         fed;
    logic       exp_rco;
    logic       din;
    logic [7:0] last_w;
    logic [9:0] o;
    for (int g = 0; g < 16; g++) begin
      if ((((cyc + 1) % 8) == 4) == align) break;
      step();
    end
    last_w = exp_last[sel];
    set_des(sel, 1'b1, 1'b1);
    step();
    set_des(sel, 1'b0, 1'b0);
    o = des_obs(sel);
    check_eq({tag, " busy@start"}, 32'(o[9]), 32'd1);
    check_eq({tag, " rco@start"}, 32'(o[8]), 32'd0);
    k = 0;
    r = 0;
    for (int g = 0; g < 400 && k < stop_at; g++) begin
      fed = (((cyc + 1) % 8) == 4) && (k < len);
      din = fed ? stream[len - 1 - k] : 1'($urandom);
      set_des(sel, 1'b0, din);
      step();
      if (fed) k++;
      exp_rco = fed && ((k % 8 == 0) || (k == len));
      o = des_obs(sel);
      check_eq({tag, " rco"}, 32'(o[8]), 32'(exp_rco));
      if (exp_rco) begin
        last_w = (r == 0) ? w0 : w1;
        r++;
      end
      check_eq({tag, " data"}, 32'(o[7:0]), 32'(last_w));
      check_eq({tag, " busy"}, 32'(o[9]), 32'(k < len));
    end
    check_eq({tag, " progress"}, 32'(k), 32'(stop_at));
    exp_last[sel] = last_w;
    if (stop_at == len) begin
      for (int g = 0; g < 10; g++) begin
        set_des(sel, 1'b0, 1'($urandom));
        step();
        o = des_obs(sel);
        check_eq({tag, " tail rco"}, 32'(o[8]), 32'd0);
        check_eq({tag, " tail busy"}, 32'(o[9]), 32'd0);
        check_eq({tag, " tail data"}, 32'(o[7:0]), 32'(last_w));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    b16.wait_start    = 1'b0;
    b16.wait_count_to = 8'd0;
    b7.wait_start     = 1'b0;
    b7.wait_count_to  = 8'd0;
    set_des(1'b0, 1'b0, 1'b0);
    set_des(1'b1, 1'b0, 1'b0);
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    #2 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("sclk in reset", 32'(sclk16), 32'd0);
    end
    check_all_zero("reset values");
    reset = 1'b1;
    cyc   = 0;

    for (int i = 0; i < 24; i++) begin
      step();
      check_eq("sclk divider", 32'(sclk16), 32'((cyc / 4) % 2));
    end

    run_wait(8'd5, 1'b1, "wait5");
    run_wait(8'd0, 1'b0, "wait0");

    run_capture(1'b0, 1'b0, 16'hA53C, 16, 8'hA5, 8'h3C, 16, "des16");
    run_capture(1'b0, 1'b1, 16'h5AC3, 16, 8'h5A, 8'hC3, 16, "des16 aligned");
    run_capture(1'b1, 1'b0, 16'h0059, 7, 8'h59, 8'h00, 7, "des7");

    // Abort a 7-bit capture after 3 bits with an asynchronous reset.
    run_capture(1'b1, 1'b0, 16'h0033, 7, 8'h00, 8'h00, 3, "des7 abort");
    #2 reset = 1'b0;
    #1;
    check_all_zero("mid reset");
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rco in reset", 32'(b7.des_rco), 32'd0);
    end
    reset = 1'b1;
    cyc   = 0;
    run_capture(1'b1, 1'b0, 16'h0033, 7, 8'h33, 8'h00, 7, "des7 fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_spi_rx_timing.md
Name: sd_spi_rx_timing

Overview:
- Timing and receive datapath for the SD-card SPI reader.
- Combines three functions in one fast-clock domain:
  - a programmable SCLK divider;
  - a wait counter that counts SCLK edges;
  - a MISO deserializer with bit counting that emits bytes to the FIFO-push path.
- The controlling FSM runs on the fast clock and issues single-cycle start pulses. Each sub-function must raise busy on the very next fast clock so the FSM's wait-while-busy checks are valid.

Parameters:
- IN_FREQ, 250: input clock frequency in arbitrary units.
- OUT_FREQ, 2: SCLK frequency in the same units.
- COUNTER_SIZE, 8: width of wait_count_to.
- DATA_LENGTH, 4096: bits captured per deserializer run.
- WORD_SIZE, 8: bits per emitted word.

Ports:
- clock, input, 1: fast system clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-low reset; 0 clears all state immediately.
- sclk, output, 1: divided SPI clock.
- wait_start, input, 1: start pulse for the wait counter.
- wait_count_to, input, COUNTER_SIZE: number of SCLK rising edges to wait.
- wait_busy, output, 1: wait counter active.
- des_start, input, 1: start pulse for the deserializer.
- des_data_in, input, 1: serial input (MISO).
- des_data_out, output, WORD_SIZE: last completed word.
- des_busy, output, 1: deserializer capturing.
- des_rco, output, 1: one-cycle strobe, des_data_out newly valid (FIFO push).

Behaviour:
- Reset values (reset=0): sclk=0, wait_busy=0, des_busy=0, des_rco=0, des_data_out=0; all counters and the shift register cleared.
- Reset asserted mid-operation aborts the operation with no rco.
- Divider:
  - HALF = max(1, IN_FREQ/(2*OUT_FREQ)), integer division; default 62.
  - Counter runs 0..HALF-1; on reaching HALF-1 it resets to 0 and sclk toggles. SCLK period is therefore 2*HALF clocks.
  - rise_tick is an internal one-clock strobe asserted in the cycle where sclk is 0 and the counter is at HALF-1, i.e. the cycle in which sclk goes 0 to 1.
  - The divider free-runs regardless of starts.
- Wait counter:
  - wait_start=1 while idle: latch wait_count_to, zero the edge count, set wait_busy=1 on the next clock.
  - Each rise_tick while busy increments the count. When the count reaches the latched value, wait_busy clears on that clock edge. count_to=0 clears at the first rise_tick.
  - wait_start while busy is ignored.
  - If start and rise_tick coincide, that tick is not counted.
- Deserializer:
  - des_start=1 while idle: clear the shift register, bit and word counters; des_busy=1 next clock.
  - Each rise_tick while busy: shift register <= {shift[WORD_SIZE-2:0], des_data_in}, MSB first; total++ and word++.
  - When word==WORD_SIZE or total==DATA_LENGTH:
    - des_data_out <= the new shift value;
    - des_rco=1 for exactly one clock;
    - word counter and shift register reset.
  - A final partial word is right-aligned with upper bits 0.
  - When total==DATA_LENGTH, des_busy clears on the same edge that raises the final des_rco.
  - des_data_out holds until the next word.
  - des_start while busy is ignored. Start coinciding with rise_tick: that tick is not captured.
  - des_rco is 0 at all other times.
- The two sub-functions are independent and may run simultaneously.

Test Plan:
- IN_FREQ=8, OUT_FREQ=1, reset released:
  - sclk toggles every 4 clocks, period 8.
  - sclk=0 throughout reset.
- Wait, count_to=5, pulse wait_start:
  - wait_busy=1 on the next clock.
  - Clears on the 5th subsequent sclk rising edge.
  - A second wait_start while busy has no effect.
- Deserializer, DATA_LENGTH=16, WORD_SIZE=8, MISO stream 0xA5 then 0x3C MSB-first:
  - des_rco pulses twice, one clock each, with des_data_out=0xA5 then 0x3C.
  - des_busy falls with the second pulse.
- DATA_LENGTH=7, WORD_SIZE=8, stream 1,0,1,1,0,0,1:
  - single des_rco with des_data_out=0x59.
  - busy clears at the same edge.
- Reset mid-capture after 3 bits:
  - all outputs return to 0 immediately, no rco.
  - A subsequent start captures a clean fresh word.
- des_start asserted in the same clock as rise_tick:
  - that edge's MISO bit is excluded.
  - The first captured bit comes from the next sclk rise.
